// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction width, instruction-memory address width
// and the program-loader state encoding. Used by the loader and by the core's
// fetch path, so changing IMEM_ADDR_W resizes both sides together.
package cpu_pkg;

  localparam int INSTR_W     = 16;
  localparam int IMEM_ADDR_W = 8;

  typedef enum logic [2:0] {
    LEN_HI  = 3'd0,
    LEN_LO  = 3'd1,
    DATA_HI = 3'd2,
    DATA_LO = 3'd3,
    CHECK   = 3'd4,
    DONE    = 3'd5,
    ERROR   = 3'd6
  } loader_state_t;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// master: the side that sources bytes and observes writes (stream + memory).
// slave: the loader itself.
interface prog_loader_if #(
  parameter int ADDR_W  = cpu_pkg::IMEM_ADDR_W,
  parameter int INSTR_W = cpu_pkg::INSTR_W
);

  logic [7:0]         in_data;
  logic               in_valid;
  logic               in_ready;
  logic               imem_we;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_wdata;

  modport master (
    output in_data, in_valid,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, imem_we, imem_addr, imem_wdata
  );

endinterface

// File: rtl/prog_loader.sv
// Boot loader: parses LEN_HI LEN_LO {hi lo}*N CHK and writes words into imem.
// Latency: write strobe one cycle after each DATA_LO byte; done/error one cycle after CHK/LEN_LO.
// Backpressure: in_ready from state only; low only in DONE, bytes swallowed in ERROR.
module prog_loader
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = cpu_pkg::IMEM_ADDR_W,
  parameter int INSTR_W = cpu_pkg::INSTR_W
) (
  input  logic             clk,
  input  logic             rst,
  prog_loader_if.slave     bus,
  input  logic             reload,
  output logic             cpu_hold,
  output logic             done,
  output logic             error
);

  // Largest legal word count: the whole memory.
  localparam logic [16:0] MAX_N = 17'(1) << ADDR_W;

  loader_state_t        state, state_nxt;
  logic [ADDR_W:0]      cnt;        // words written so far, reaches 2**ADDR_W
  logic [ADDR_W:0]      len;        // word count N, only kept when legal
  logic [7:0]           len_hi;
  logic [7:0]           hi_byte;
  logic [7:0]           xsum;       // running XOR of LEN_HI..last data byte
  logic                 xfer;
  logic [16:0]          n_ext;      // {LEN_HI, current byte} as a word count
  logic [ADDR_W:0]      cnt_inc;

  assign bus.in_ready = (state != DONE);
  assign xfer         = bus.in_valid && bus.in_ready;
  assign n_ext        = {1'b0, len_hi, bus.in_data};
  assign cnt_inc      = cnt + 1'b1;

  // Next-state decode; reload overrides any byte transfer in the same cycle.
  always_comb begin
    state_nxt = state;
    if (reload) begin
      state_nxt = LEN_HI;
    end else if (xfer) begin
      case (state)
        LEN_HI:  state_nxt = LEN_LO;
        LEN_LO: begin
          if (n_ext > MAX_N)       state_nxt = ERROR;
          else if (n_ext == 17'd0) state_nxt = CHECK;
          else                     state_nxt = DATA_HI;
        end
        DATA_HI: state_nxt = DATA_LO;
        DATA_LO: state_nxt = (cnt_inc == len) ? CHECK : DATA_HI;
        CHECK:   state_nxt = (bus.in_data == xsum) ? DONE : ERROR;
        DONE:    state_nxt = DONE;
        ERROR:   state_nxt = ERROR;
        default: state_nxt = ERROR;
      endcase
    end
  end

  // State register and registered status outputs derived from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= LEN_HI;
      done     <= 1'b0;
      error    <= 1'b0;
      cpu_hold <= 1'b1;
    end else begin
      state    <= state_nxt;
      done     <= (state_nxt == DONE);
      error    <= (state_nxt == ERROR);
      cpu_hold <= (state_nxt != DONE);
    end
  end

  // Datapath: length capture, high-byte latch, checksum and memory write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt            <= '0;
      len            <= '0;
      len_hi         <= '0;
      hi_byte        <= '0;
      xsum           <= '0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
    end else begin
      bus.imem_we <= 1'b0;
      if (reload) begin
        cnt            <= '0;
        len            <= '0;
        len_hi         <= '0;
        hi_byte        <= '0;
        xsum           <= '0;
        bus.imem_addr  <= '0;
        bus.imem_wdata <= '0;
      end else if (xfer) begin
        case (state)
          LEN_HI: begin
            len_hi <= bus.in_data;
            xsum   <= xsum ^ bus.in_data;
          end
          LEN_LO: begin
            len  <= n_ext[ADDR_W:0];
            xsum <= xsum ^ bus.in_data;
          end
          DATA_HI: begin
            hi_byte <= bus.in_data;
            xsum    <= xsum ^ bus.in_data;
          end
          DATA_LO: begin
            bus.imem_we    <= 1'b1;
            bus.imem_addr  <= cnt[ADDR_W-1:0];
            bus.imem_wdata <= {hi_byte, bus.in_data};
            cnt            <= cnt_inc;
            xsum           <= xsum ^ bus.in_data;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: good/bad frames, size limits, reload and reset.
// Writes are collected by a monitor on the falling edge and compared afterwards.
// Inputs are driven 1 time unit after the rising edge.
module tb_prog_loader;
  import cpu_pkg::*;

  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic reload = 1'b0;
  logic cpu_hold, done, error;

  int n_checks = 0;
  int n_errors = 0;

  logic [AW-1:0] wa[$];
  logic [15:0]   wd[$];

  prog_loader_if #(.ADDR_W(AW), .INSTR_W(16)) lif ();

  prog_loader #(.ADDR_W(AW), .INSTR_W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (lif),
    .reload   (reload),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  // Record every write strobe seen mid-cycle.
  always @(negedge clk) begin
    if (lif.imem_we === 1'b1) begin
      wa.push_back(lif.imem_addr);
      wd.push_back(lif.imem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one byte and hold it until the loader takes it (bounded wait).
  task automatic send(input logic [7:0] b);
    bit taken = 1'b0;
    lif.in_data  = b;
    lif.in_valid = 1'b1;
    for (int i = 0; i < 50 && !taken; i++) begin
      @(negedge clk);
      if (lif.in_ready === 1'b1) taken = 1'b1;
      else @(posedge clk);
    end
    if (!taken) check("send_timeout", {31'd0, lif.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    lif.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
    wa.delete();
    wd.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, {31'd0, lif.in_ready}, 32'd1);
    check({tag, "_we"},       {31'd0, lif.imem_we},  32'd0);
    check({tag, "_addr"},     {24'd0, lif.imem_addr}, 32'd0);
    check({tag, "_wdata"},    {16'd0, lif.imem_wdata}, 32'd0);
    check({tag, "_hold"},     {31'd0, cpu_hold}, 32'd1);
    check({tag, "_done"},     {31'd0, done}, 32'd0);
    check({tag, "_error"},    {31'd0, error}, 32'd0);
  endtask

  task automatic check_two_writes(input string tag);
    check({tag, "_nwr"}, wa.size(), 32'd2);
    if (wa.size() == 2) begin
      check({tag, "_a0"}, {24'd0, wa[0]}, 32'h00);
      check({tag, "_d0"}, {16'd0, wd[0]}, 32'h1234);
      check({tag, "_a1"}, {24'd0, wa[1]}, 32'h01);
      check({tag, "_d1"}, {16'd0, wd[1]}, 32'hABCD);
    end
  endtask

  logic [7:0] frame [7];
  logic [7:0] xs;
  int bad;

  initial begin
    frame[0] = 8'h00; frame[1] = 8'h02; frame[2] = 8'h12; frame[3] = 8'h34;
    frame[4] = 8'hAB; frame[5] = 8'hCD; frame[6] = 8'h42;
    lif.in_data  = 8'h00;
    lif.in_valid = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst");
    rst = 1'b0;
    idle(1);
    check_reset_vals("post_rst");

    // Good two-word frame
    for (int i = 0; i < 7; i++) send(frame[i]);
    check("good_done", {31'd0, done}, 32'd1);
    check("good_hold", {31'd0, cpu_hold}, 32'd0);
    check("good_err", {31'd0, error}, 32'd0);
    check("good_rdy", {31'd0, lif.in_ready}, 32'd0);
    idle(2);
    check("good_rdy_later", {31'd0, lif.in_ready}, 32'd0);
    check_two_writes("good");

    // Bad checksum: writes still happen, then error, extra bytes swallowed
    do_reload();
    check_reset_vals("reload");
    for (int i = 0; i < 6; i++) send(frame[i]);
    send(8'h43);
    check("badchk_err", {31'd0, error}, 32'd1);
    check("badchk_hold", {31'd0, cpu_hold}, 32'd1);
    check("badchk_done", {31'd0, done}, 32'd0);
    send(8'h55);
    send(8'hAA);
    check("badchk_rdy", {31'd0, lif.in_ready}, 32'd1);
    check("badchk_err2", {31'd0, error}, 32'd1);
    check_two_writes("badchk");

    // Empty frames
    do_reload();
    send(8'h00); send(8'h00); send(8'h00);
    check("empty_done", {31'd0, done}, 32'd1);
    check("empty_nwr", wa.size(), 32'd0);
    do_reload();
    send(8'h00); send(8'h00); send(8'h01);
    check("empty_bad_err", {31'd0, error}, 32'd1);
    check("empty_bad_done", {31'd0, done}, 32'd0);

    // Oversized length 257
    do_reload();
    send(8'h01);
    check("big_err_early", {31'd0, error}, 32'd0);
    send(8'h01);
    check("big_err", {31'd0, error}, 32'd1);
    check("big_nwr", wa.size(), 32'd0);

    // Full memory: 256 words, hi=i, lo=~i
    do_reload();
    xs = 8'h01 ^ 8'h00;
    send(8'h01); send(8'h00);
    for (int i = 0; i < 256; i++) begin
      logic [7:0] h, l;
      h = 8'(i);
      l = ~h;
      xs = xs ^ h ^ l;
      send(h);
      send(l);
    end
    send(xs);
    check("full_done", {31'd0, done}, 32'd1);
    check("full_nwr", wa.size(), 32'd256);
    bad = 0;
    for (int i = 0; i < wa.size(); i++) begin
      logic [7:0] h;
      h = 8'(i);
      if (wa[i] !== h || wd[i] !== {h, ~h}) bad++;
    end
    check("full_data_bad", bad, 32'd0);
    if (wa.size() > 0) check("full_last_addr", {24'd0, wa[wa.size()-1]}, 32'hFF);

    // Reload colliding with a byte transfer: byte is dropped
    do_reload();
    send(8'h00); send(8'h02); send(8'h12);
    lif.in_data  = 8'h34;
    lif.in_valid = 1'b1;
    reload       = 1'b1;
    @(posedge clk);
    #1;
    reload       = 1'b0;
    lif.in_valid = 1'b0;
    check("rl_we", {31'd0, lif.imem_we}, 32'd0);
    check("rl_hold", {31'd0, cpu_hold}, 32'd1);
    idle(1);
    check("rl_nwr_dropped", wa.size(), 32'd0);
    for (int i = 0; i < 7; i++) send(frame[i]);
    check("rl_done", {31'd0, done}, 32'd1);
    check_two_writes("rl");

    // Random gaps between bytes
    do_reload();
    for (int i = 0; i < 7; i++) begin
      idle($urandom_range(0, 3));
      send(frame[i]);
    end
    check("gap_done", {31'd0, done}, 32'd1);
    check_two_writes("gap");

    // Asynchronous reset while waiting in DATA_LO after one write
    do_reload();
    for (int i = 0; i < 5; i++) send(frame[i]);
    check("pre_rst_wdata", {16'd0, lif.imem_wdata}, 32'h1234);
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals("async_rst");
    @(negedge clk);
    rst = 1'b0;
    idle(1);
    check("after_rst_rdy", {31'd0, lif.in_ready}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader that fills the CPU's 16-bit instruction memory from a byte stream, such as a UART receiver, while holding the core in reset. It is the write side of the instruction-memory port: the core's fetch path only reads that memory, and this block is the only writer. When a load finishes with a valid checksum, the block releases the core, which then starts fetching at address 0.

## Interface
Parameters:
- ADDR_W, 8, instruction-memory address width; capacity is 2**ADDR_W words.
- INSTR_W, 16, instruction width; fixed at 16, two bytes per word.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  8  incoming stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  the loader accepts the byte this cycle.
- reload  in  1  single-cycle pulse that aborts and restarts loading.
- imem_we  out  1  instruction-memory write strobe, one cycle per word.
- imem_addr  out  ADDR_W  write address.
- imem_wdata  out  INSTR_W  write data.
- cpu_hold  out  1  holds the core in reset while high.
- done  out  1  load completed with a good checksum.
- error  out  1  load failed; the cause is an oversized length or a bad checksum.

## Operation
- Frame format: LEN_HI, LEN_LO, then N words sent high byte first, then CHK.
  - N = {LEN_HI, LEN_LO} is the word count.
  - CHK is the XOR of every frame byte from LEN_HI through the last data byte.
- A byte transfers when in_valid && in_ready.
- The stream may pause for any number of cycles between bytes.
- States:
  - LEN_HI: accept LEN_HI, go to LEN_LO.
  - LEN_LO: accept LEN_LO.
    - If N > 2**ADDR_W, go to ERROR.
    - If N == 0, go to CHECK.
    - Otherwise go to DATA_HI.
  - DATA_HI: accept the byte, latch it as the high byte, go to DATA_LO.
  - DATA_LO: accept the byte and issue a write of {hi, lo} at the word counter; the counter then increments.
    - If the counter is now N, go to CHECK.
    - Otherwise go to DATA_HI.
  - CHECK: accept CHK.
    - If CHK equals the running XOR, go to DONE.
    - Otherwise go to ERROR.
  - DONE: in_ready=0, done=1, cpu_hold=0. The block stays here until reload or rst.
  - ERROR: in_ready=1, bytes are discarded so the source never stalls, error=1, cpu_hold=1. The block stays here until reload or rst.
- in_ready is 1 in LEN_HI through CHECK and in ERROR, and 0 in DONE.
- The word counter is ADDR_W+1 bits wide so that N = 2**ADDR_W is reachable. imem_addr is its low ADDR_W bits.
- The running XOR clears on entry to LEN_HI.
- Words already written before an error are not rolled back.
- reload: in any state, the next state is LEN_HI.
  - Counter and XOR clear; done, error and imem_we go to 0; cpu_hold goes to 1.
  - reload has priority over a byte transfer in the same cycle. That byte is dropped.

## Timing
- Reset values:
  - state LEN_HI, in_ready 1, imem_we 0, imem_addr 0, imem_wdata 0.
  - cpu_hold 1, done 0, error 0.
- All outputs except in_ready are registered. in_ready is decoded from the state register only, with no path from in_valid.
- Throughput: one byte per cycle, so one word per two cycles.
- Write latency: imem_we/addr/wdata are valid for exactly the one cycle after the DATA_LO transfer.
- Completion latency:
  - done and cpu_hold=0 appear the cycle after the CHK transfer.
  - The last imem_we is at least one cycle earlier, so the core never fetches a half-written word.
- error appears the cycle after the offending LEN_LO or CHK transfer.
- A reload pulse takes effect at the next edge; in the following cycle the outputs hold their reset values.
- rst asserted mid-load forces reset values immediately, with no clock needed.

## Structure
- The shared package `cpu_pkg` holds:
  - the `loader_state_t` enum (LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, DONE, ERROR);
  - INSTR_W;
  - the instruction-memory address-width constant, which the core's fetch path also uses.
- Single module with no sub-modules. The checksum is one XOR register, not a separate block.
- The CPU top gates its program-counter reset with `rst | cpu_hold`.

## Test plan
- Stream 00 02 12 34 AB CD 42 -> writes 0x1234@0 and 0xABCD@1, each a one-cycle imem_we; next, done=1 and cpu_hold=0; in_ready=0 afterwards.
- Same frame with CHK=43 -> both writes occur, then error=1, cpu_hold=1; the following bytes are accepted and ignored.
- Stream 00 00 00 -> no imem_we, done=1. Stream 00 00 01 -> error=1.
- With ADDR_W=8, stream 01 01 -> error=1 the cycle after the second byte, no writes. Stream 01 00 plus 512 data bytes and a correct CHK -> 256 writes, last at address 0xFF, then done=1.
- Stream 00 02 12, then reload in the same cycle as byte 34 with in_valid high -> 34 dropped; the full frame from the first test then loads at addresses 0 and 1.
- Random in_valid gaps on the first test's frame -> identical writes. rst mid-DATA_LO -> all outputs at reset values the same cycle.
